// File: rtl/sipo_frame_capture_pkg.sv
// Shared types and defaults for the serial-to-parallel frame capture stage.
package sipo_frame_capture_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

endpackage : sipo_frame_capture_pkg

// File: rtl/sipo_shifter.sv
// WIDTH-bit enabled shift register with selectable direction and synchronous clear.
// Exposes the next-state word so the parent can capture a frame on its final bit.
module sipo_shifter
  import sipo_frame_capture_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] shift_next
);

  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;

  always_comb begin
    shift_d = shift_q;
    if (clr) begin
      shift_d = '0;
    end else if (en) begin
      shift_d = MSB_FIRST ? {shift_q[WIDTH-2:0], din} : {din, shift_q[WIDTH-1:1]};
    end
  end

  // NOTE: the shift register is reset even though every bit is overwritten per frame;
  // this keeps a mid-frame reset from leaking stale bits into X-pessimistic checks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign shift_next = shift_d;

endmodule : sipo_shifter

// File: rtl/sipo_frame_capture.sv
// Assembles WIDTH-bit words from a registered serial stream and offers them downstream
// over valid/ready, flagging a sticky overrun when a completed word cannot be held.
module sipo_frame_capture
  import sipo_frame_capture_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             shift_en,
  input  logic             start,
  input  logic             data_ready,
  input  logic             clear_overrun,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             busy,
  output logic             overrun
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;

  logic             shifting;
  logic             complete;
  logic [WIDTH-1:0] shift_next;

  // A start strobe always wins over sampling, so a restart never takes a bit that cycle.
  assign shifting = (state_q == SHIFT) && !start && shift_en;
  assign complete = shifting && (count_q == LAST_BIT);

  sipo_shifter #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_shifter (
    .clk       (clk),
    .reset     (reset),
    .clr       (start),
    .en        (shifting),
    .din       (serial_in),
    .shift_next(shift_next)
  );

  // NOTE: every _d gets its hold value first so no path through this block infers a latch.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q && !clear_overrun;

    if (start) begin
      state_d = SHIFT;
      count_d = '0;
    end else if (shifting) begin
      if (complete) begin
        state_d = IDLE;
        count_d = '0;
      end else begin
        count_d = count_q + 1'b1;
      end
    end

    if (valid_q && data_ready) begin
      valid_d = 1'b0;
    end

    // A word completing into a full, unaccepted output slot is dropped; set beats clear.
    if (complete) begin
      if (!valid_q || data_ready) begin
        data_d  = shift_next;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // NOTE: non-blocking assignments here so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign busy       = (state_q == SHIFT);
  assign overrun    = overrun_q;

endmodule : sipo_frame_capture

// File: tb/tb_sipo_frame_capture.sv
// Scoreboard bench: MSB-first and LSB-first instances share one serial stream; every
// accepted word is popped from an expected queue and compared on both instances.
module tb_sipo_frame_capture;

  logic       clk = 1'b0;
  logic       reset;
  logic       serial_in;
  logic       shift_en;
  logic       start;
  logic       data_ready;
  logic       clear_overrun;
  logic [7:0] m_data, l_data;
  logic       m_valid, l_valid, m_busy, l_busy, m_ovr, l_ovr;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  sipo_frame_capture #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset(reset), .serial_in(serial_in), .shift_en(shift_en), .start(start),
    .data_ready(data_ready), .clear_overrun(clear_overrun), .data_out(m_data),
    .data_valid(m_valid), .busy(m_busy), .overrun(m_ovr)
  );

  sipo_frame_capture #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .serial_in(serial_in), .shift_en(shift_en), .start(start),
    .data_ready(data_ready), .clear_overrun(clear_overrun), .data_out(l_data),
    .data_valid(l_valid), .busy(l_busy), .overrun(l_ovr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one frame MSB of w first; push the word if it is expected to reach the output.
  task automatic send_frame(input logic [7:0] w, input bit push, input bit gap,
                            input bit rdy_last);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      serial_in = w[i];
      shift_en  = 1'b1;
      if (i == 0) begin
        if (push) exp_q.push_back(w);
        if (rdy_last) data_ready = 1'b1;
      end
      tick();
      shift_en = 1'b0;
      if (gap && i == 4) begin
        serial_in = 1'b1;
        for (int g = 0; g < 3; g++) begin
          tick();
          check("gap_busy", 32'(m_busy), 32'd1);
          check("gap_count", 32'(dut_msb.count_q), 32'd4);
        end
      end
    end
  endtask

  // Monitor: a transfer happens at the next edge whenever valid and ready are both high.
  always @(negedge clk) begin
    if (!reset && m_valid && data_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_valid", 32'd1, 32'd0);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("sb_msb_word", 32'(m_data), 32'(e));
        check("sb_lsb_word", 32'(l_data), 32'(rev8(e)));
        check("sb_lsb_valid", 32'(l_valid), 32'd1);
      end
    end
  end

  initial begin
    reset = 1'b1; serial_in = 1'b0; shift_en = 1'b0; start = 1'b0;
    data_ready = 1'b0; clear_overrun = 1'b0;
    #12;
    check("rst_data", 32'(m_data), 32'd0);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_busy", 32'(m_busy), 32'd0);
    check("rst_ovr", 32'(m_ovr), 32'd0);
    reset = 1'b0;
    tick();

    // Basic frame, both bit orders.
    data_ready = 1'b1;
    send_frame(8'hB2, 1'b1, 1'b0, 1'b0);
    check("basic_msb", 32'(m_data), 32'hB2);
    check("basic_lsb", 32'(l_data), 32'h4D);
    check("basic_valid", 32'(m_valid), 32'd1);
    check("basic_busy", 32'(m_busy), 32'd0);
    tick();
    check("basic_valid_1cyc", 32'(m_valid), 32'd0);

    // Enable gap mid-frame.
    send_frame(8'hB2, 1'b1, 1'b1, 1'b0);
    check("gap_word", 32'(m_data), 32'hB2);
    check("gap_valid", 32'(m_valid), 32'd1);
    tick();

    // Overrun: second word dropped while the first is held.
    data_ready = 1'b0;
    send_frame(8'hB2, 1'b1, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    check("ovr_hold_data", 32'(m_data), 32'hB2);
    check("ovr_flag", 32'(m_ovr), 32'd1);
    check("ovr_valid", 32'(m_valid), 32'd1);
    tick();
    check("ovr_sticky", 32'(m_ovr), 32'd1);
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    check("ovr_drain_valid", 32'(m_valid), 32'd0);
    check("ovr_after_drain", 32'(m_ovr), 32'd1);
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    check("ovr_cleared", 32'(m_ovr), 32'd0);

    // Completion while full but ready on that edge: replace, no overrun.
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(8'hC7, 1'b1, 1'b0, 1'b1);
    check("swap_data", 32'(m_data), 32'hC7);
    check("swap_valid", 32'(m_valid), 32'd1);
    check("swap_no_ovr", 32'(m_ovr), 32'd0);
    tick();

    // Restart after 5 bits: aborted frame never surfaces.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      serial_in = i[0];
      shift_en  = 1'b1;
      tick();
    end
    shift_en = 1'b0;
    check("restart_no_valid", 32'(m_valid), 32'd0);
    check("restart_busy", 32'(m_busy), 32'd1);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    check("restart_word", 32'(m_data), 32'h3C);
    tick();

    // Async reset between edges, mid-frame.
    data_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      serial_in = 1'b1;
      shift_en  = 1'b1;
      tick();
    end
    shift_en = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("arst_data", 32'(m_data), 32'd0);
    check("arst_valid", 32'(m_valid), 32'd0);
    check("arst_busy", 32'(m_busy), 32'd0);
    check("arst_ovr", 32'(m_ovr), 32'd0);
    #1;
    reset = 1'b0;
    tick();
    data_ready = 1'b1;
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
    check("arst_frame", 32'(m_data), 32'hFF);
    check("arst_frame_lsb", 32'(l_data), 32'hFF);
    tick();
    tick();

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_sipo_frame_capture
